// File: rtl/piece_controller.sv
// Falling-tetromino controller: spawns on gen_flag, applies gravity and player moves,
// and reports the landed cells to the board via bottom_flag or a blocked spawn via top_flag.
module piece_controller #(
  parameter int DROP_DIV = 25000000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       gen_flag,
  input  logic       started,
  input  logic [9:0] arr0,
  input  logic [9:0] arr1,
  input  logic [9:0] arr2,
  input  logic [9:0] arr3,
  input  logic [9:0] arr4,
  input  logic [9:0] arr5,
  input  logic [9:0] arr6,
  input  logic [9:0] arr7,
  input  logic [9:0] arr8,
  input  logic [9:0] arr9,
  input  logic [9:0] arr10,
  input  logic [9:0] arr11,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_rot,
  input  logic       btn_drop,
  output logic [3:0] x1,
  output logic [3:0] y1,
  output logic [3:0] x2,
  output logic [3:0] y2,
  output logic [3:0] x3,
  output logic [3:0] y3,
  output logic [3:0] x4,
  output logic [3:0] y4,
  output logic       bottom_flag,
  output logic       top_flag,
  output logic [2:0] piece_type,
  output logic [2:0] state
);

  // Handshake: the board pulses gen_flag for one cycle (honoured only in IDLE/WAIT);
  // bottom_flag is a one-cycle pulse with the landed cells stable, top_flag is a level.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SPAWN = 3'd1,
    FALL  = 3'd2,
    HARD  = 3'd3,
    LAND  = 3'd4,
    WAIT  = 3'd5,
    OVER  = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    MV_NONE,
    MV_STAY,
    MV_DOWN,
    MV_LEFT,
    MV_RIGHT,
    MV_ROT
  } move_t;

  localparam int CW = (DROP_DIV > 1) ? $clog2(DROP_DIV) : 1;

  state_t     st;
  logic [CW-1:0] cnt;
  logic [2:0] sel;
  logic [3:0] cx [4];
  logic [3:0] cy [4];
  logic [9:0] rows [12];

  move_t             mv;
  logic              tick;
  logic              cand_ok;
  logic signed [4:0] nx [4];
  logic signed [4:0] ny [4];
  logic [15:0]       spawn_x;
  logic [15:0]       spawn_y;

  assign rows[0]  = arr0;
  assign rows[1]  = arr1;
  assign rows[2]  = arr2;
  assign rows[3]  = arr3;
  assign rows[4]  = arr4;
  assign rows[5]  = arr5;
  assign rows[6]  = arr6;
  assign rows[7]  = arr7;
  assign rows[8]  = arr8;
  assign rows[9]  = arr9;
  assign rows[10] = arr10;
  assign rows[11] = arr11;

  assign x1 = cx[0];
  assign y1 = cy[0];
  assign x2 = cx[1];
  assign y2 = cy[1];
  assign x3 = cx[2];
  assign y3 = cy[2];
  assign x4 = cx[3];
  assign y4 = cy[3];
  assign state = st;

  // Spawn table, cell 0 (pivot) in the top nibble.
  always_comb begin
    spawn_x = 16'h0000;
    spawn_y = 16'h0000;
    case (sel)
      3'd0:    begin spawn_x = 16'h4356; spawn_y = 16'hBBBB; end
      3'd1:    begin spawn_x = 16'h4545; spawn_y = 16'hAABB; end
      3'd2:    begin spawn_x = 16'h4354; spawn_y = 16'hAAAB; end
      3'd3:    begin spawn_x = 16'h4345; spawn_y = 16'hAABB; end
      3'd4:    begin spawn_x = 16'h4543; spawn_y = 16'hAABB; end
      3'd5:    begin spawn_x = 16'h4353; spawn_y = 16'hAAAB; end
      3'd6:    begin spawn_x = 16'h4355; spawn_y = 16'hAAAB; end
      default: begin spawn_x = 16'h0000; spawn_y = 16'h0000; end
    endcase
  end

  always_comb begin
    tick = (st == FALL) && (cnt == CW'(DROP_DIV - 1));
    mv   = MV_NONE;
    case (st)
      SPAWN: mv = MV_STAY;
      HARD:  mv = MV_DOWN;
      FALL: begin
        if (tick)                       mv = MV_DOWN;
        else if (btn_drop)              mv = MV_NONE;
        else if (btn_rot)               mv = (piece_type == 3'd1) ? MV_NONE : MV_ROT;
        else if (btn_left && !btn_right) mv = MV_LEFT;
        else if (btn_right && !btn_left) mv = MV_RIGHT;
        else                            mv = MV_NONE;
      end
      default: mv = MV_NONE;
    endcase
  end

  always_comb begin
    cand_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nx[i] = $signed({1'b0, cx[i]});
      ny[i] = $signed({1'b0, cy[i]});
      case (mv)
        MV_DOWN:  ny[i] = $signed({1'b0, cy[i]}) - 5'sd1;
        MV_LEFT:  nx[i] = $signed({1'b0, cx[i]}) - 5'sd1;
        MV_RIGHT: nx[i] = $signed({1'b0, cx[i]}) + 5'sd1;
        // Clockwise about the pivot: (dx,dy) -> (dy,-dx).
        MV_ROT: begin
          nx[i] = $signed({1'b0, cx[0]}) + ($signed({1'b0, cy[i]}) - $signed({1'b0, cy[0]}));
          ny[i] = $signed({1'b0, cy[0]}) - ($signed({1'b0, cx[i]}) - $signed({1'b0, cx[0]}));
        end
        default: begin
          nx[i] = $signed({1'b0, cx[i]});
          ny[i] = $signed({1'b0, cy[i]});
        end
      endcase
      if (nx[i] < 5'sd0 || nx[i] > 5'sd9 || ny[i] < 5'sd0 || ny[i] > 5'sd11)
        cand_ok = 1'b0;
      else if (rows[ny[i][3:0]][nx[i][3:0]])
        cand_ok = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      st          <= IDLE;
      cnt         <= '0;
      sel         <= 3'd0;
      bottom_flag <= 1'b0;
      top_flag    <= 1'b0;
      piece_type  <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        cx[i] <= 4'd0;
        cy[i] <= 4'd0;
      end
    end else begin
      sel         <= (sel == 3'd6) ? 3'd0 : sel + 3'd1;
      bottom_flag <= 1'b0;
      if (st != IDLE && !started) begin
        st       <= IDLE;
        top_flag <= 1'b0;
      end else begin
        case (st)
          IDLE, WAIT: begin
            if (gen_flag) begin
              piece_type <= sel;
              for (int i = 0; i < 4; i++) begin
                cx[i] <= spawn_x[15 - 4*i -: 4];
                cy[i] <= spawn_y[15 - 4*i -: 4];
              end
              st <= SPAWN;
            end
          end
          SPAWN: begin
            cnt <= '0;
            if (!cand_ok) begin
              st       <= OVER;
              top_flag <= 1'b1;
            end else begin
              st <= FALL;
            end
          end
          FALL: begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick && !cand_ok) begin
              st          <= LAND;
              bottom_flag <= 1'b1;
            end else if (!tick && btn_drop) begin
              st <= HARD;
            end else if (mv != MV_NONE && cand_ok) begin
              for (int i = 0; i < 4; i++) begin
                cx[i] <= nx[i][3:0];
                cy[i] <= ny[i][3:0];
              end
            end
          end
          HARD: begin
            if (cand_ok) begin
              for (int i = 0; i < 4; i++) cy[i] <= ny[i][3:0];
            end else begin
              st          <= LAND;
              bottom_flag <= 1'b1;
            end
          end
          LAND:    st <= WAIT;
          OVER:    top_flag <= 1'b1;
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_piece_controller.sv
// Directed bench for piece_controller: landings go through an expected queue checked by a
// monitor on bottom_flag; state and coordinate checks are made inline.
module tb_piece_controller;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       gen_flag, started;
  logic [9:0] arr0, arr1, arr2, arr3, arr4, arr5, arr6, arr7, arr8, arr9, arr10, arr11;
  logic       btn_left, btn_right, btn_rot, btn_drop;
  logic [3:0] x1, y1, x2, y2, x3, y3, x4, y4;
  logic       bottom_flag, top_flag;
  logic [2:0] piece_type, state;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  piece_controller #(.DROP_DIV(4)) dut (
    .Clk(Clk), .Reset(Reset), .gen_flag(gen_flag), .started(started),
    .arr0(arr0), .arr1(arr1), .arr2(arr2), .arr3(arr3), .arr4(arr4), .arr5(arr5),
    .arr6(arr6), .arr7(arr7), .arr8(arr8), .arr9(arr9), .arr10(arr10), .arr11(arr11),
    .btn_left(btn_left), .btn_right(btn_right), .btn_rot(btn_rot), .btn_drop(btn_drop),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2), .x3(x3), .y3(y3), .x4(x4), .y4(y4),
    .bottom_flag(bottom_flag), .top_flag(top_flag), .piece_type(piece_type), .state(state)
  );

  // Clock and watchdog
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] cells(input int ax, ay, bx, by, cx, cy, dx, dy);
    return {4'(ax), 4'(ay), 4'(bx), 4'(by), 4'(cx), 4'(cy), 4'(dx), 4'(dy)};
  endfunction

  function automatic logic [31:0] cur_cells();
    return {x1, y1, x2, y2, x3, y3, x4, y4};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic spawn_piece(input int t);
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
    repeat (t) step();
    gen_flag = 1'b1;
    step();
    gen_flag = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n;
    n = 0;
    while (state !== s && n < budget) begin
      step();
      n++;
    end
    chk(name, 32'(state), 32'(s));
  endtask

  // Scoreboard monitor: every bottom_flag pulse must match the next expected landing
  always @(negedge Clk) begin
    logic [31:0] e;
    if (!Reset && bottom_flag) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL land_unexpected: got %h expected no landing", cur_cells());
      end else begin
        e = exp_q.pop_front();
        if (cur_cells() !== e || top_flag !== 1'b0) begin
          errors++;
          $display("FAIL land_cells: got %h top=%b expected %h top=0", cur_cells(), top_flag, e);
        end
      end
    end
  end

  initial begin
    Reset = 1'b1; gen_flag = 1'b0; started = 1'b1;
    btn_left = 1'b0; btn_right = 1'b0; btn_rot = 1'b0; btn_drop = 1'b0;
    arr0 = '0; arr1 = '0; arr2 = '0; arr3 = '0; arr4 = '0; arr5 = '0;
    arr6 = '0; arr7 = '0; arr8 = '0; arr9 = '0; arr10 = '0; arr11 = '0;
    repeat (3) step();

    chk("reset_state", 32'(state), 32'd0);
    chk("reset_cells", cur_cells(), 32'd0);
    chk("reset_flags", {30'd0, bottom_flag, top_flag}, 32'd0);
    chk("reset_type", 32'(piece_type), 32'd0);

    // Spawn T on cycle 2 after release
    spawn_piece(2);
    chk("spawn_type", 32'(piece_type), 32'd2);
    chk("spawn_state", 32'(state), 32'd1);
    chk("spawn_cells", cur_cells(), cells(4, 10, 3, 10, 5, 10, 4, 11));
    step();
    chk("fall_state", 32'(state), 32'd2);

    // Gravity every 4 cycles, then landing on the floor
    chk("grav_y0", 32'(y1), 32'd10);
    repeat (3) step();
    chk("grav_no_early", 32'(y1), 32'd10);
    step();
    chk("grav_tick1", 32'(y1), 32'd9);
    repeat (4) step();
    chk("grav_tick2", 32'(y1), 32'd8);
    exp_q.push_back(cells(4, 0, 3, 0, 5, 0, 4, 1));
    wait_state(3'd5, 100, "floor_wait");
    chk("wait_cells", cur_cells(), cells(4, 0, 3, 0, 5, 0, 4, 1));
    chk("wait_bottom_low", 32'(bottom_flag), 32'd0);

    // Left presses against the wall
    spawn_piece(2);
    step();
    for (int i = 0; i < 3; i++) begin
      btn_left = 1'b1;
      step();
      btn_left = 1'b0;
      chk("left_move", 32'(x1), 32'(3 - i));
    end
    step();
    chk("left_tick_y", 32'(y1), 32'd9);
    btn_left = 1'b1;
    step();
    btn_left = 1'b0;
    chk("left_wall_x1", 32'(x1), 32'd1);
    chk("left_wall_x2", 32'(x2), 32'd0);

    // Tick beats left; both buttons cancel; right; rotate
    spawn_piece(2);
    step();
    repeat (3) step();
    btn_left = 1'b1;
    step();
    btn_left = 1'b0;
    chk("tick_vs_left", {x1, y1}, {4'd4, 4'd9});
    btn_left = 1'b1; btn_right = 1'b1;
    step();
    btn_left = 1'b0; btn_right = 1'b0;
    chk("both_buttons", 32'(x1), 32'd4);
    btn_right = 1'b1;
    step();
    btn_right = 1'b0;
    chk("right_move", 32'(x1), 32'd5);
    btn_rot = 1'b1;
    step();
    btn_rot = 1'b0;
    chk("rot_t", cur_cells(), cells(5, 9, 5, 10, 5, 8, 6, 9));

    // I at spawn cannot rotate above the top row
    spawn_piece(0);
    step();
    btn_rot = 1'b1;
    step();
    btn_rot = 1'b0;
    chk("rot_i_blocked", cur_cells(), cells(4, 11, 3, 11, 5, 11, 6, 11));

    // Blocked spawn -> OVER, cleared by started low
    arr11 = 10'b0000010000;
    spawn_piece(2);
    step();
    chk("over_state", 32'(state), 32'd6);
    chk("over_top", 32'(top_flag), 32'd1);
    repeat (3) step();
    chk("over_hold", {30'd0, top_flag, bottom_flag}, 32'd2);
    started = 1'b0;
    step();
    started = 1'b1;
    chk("over_idle", 32'(state), 32'd0);
    chk("over_top_clr", 32'(top_flag), 32'd0);
    arr11 = '0;

    // Hard drop onto a ledge in row 0
    arr0 = 10'b0000111000;
    spawn_piece(2);
    step();
    btn_drop = 1'b1;
    step();
    btn_drop = 1'b0;
    chk("hard_state", 32'(state), 32'd3);
    chk("hard_y_first", 32'(y1), 32'd10);
    step();
    chk("hard_y_next", 32'(y1), 32'd9);
    exp_q.push_back(cells(4, 1, 3, 1, 5, 1, 4, 2));
    wait_state(3'd5, 30, "hard_wait");
    arr0 = '0;

    Reset = 1'b1;
    step();
    chk("landings_pending", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
